// File: rtl/g15_pkg.sv
// rtl/g15_pkg.sv - shared types and constants for the tape reader start control
package g15_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SPINUP = 2'd1,
    READ   = 2'd2,
    BRAKE  = 2'd3
  } tape_state_t;

  localparam int SRC_AUTO   = 0;
  localparam int SRC_IO     = 1;
  localparam int SRC_MANUAL = 2;
  localparam int GRANT_W    = 3;

endpackage

// File: rtl/tape_req_latch.sv
// rtl/tape_req_latch.sv - rising-edge detector with a sticky pending bit for one request source
module tape_req_latch (
  input  logic clk,
  input  logic rst,
  input  logic req_i,
  input  logic set_ok_i,
  input  logic clr_i,
  output logic pending_o
);

  logic hist_q;
  logic pend_q;
  logic pend_d;

  // A fresh edge beats the grant-time clear so a re-request in the grant cycle is not lost;
  // set_ok low (power off) suppresses the edge so the clear always wins then.
  always_comb begin
    pend_d = pend_q;
    if (set_ok_i && req_i && !hist_q) begin
      pend_d = 1'b1;
    end else if (clr_i) begin
      pend_d = 1'b0;
    end
  end

  // History follows the input even in reset so a level held through reset is not an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      hist_q <= req_i;
      pend_q <= 1'b0;
    end else begin
      hist_q <= req_i;
      pend_q <= pend_d;
    end
  end

  assign pending_o = pend_q;

endmodule

// File: rtl/tape_start_ctl.sv
// rtl/tape_start_ctl.sv - arbitrates tape reader requests and sequences spin-up, read and brake
module tape_start_ctl
  import g15_pkg::*;
#(
  parameter int SPINUP_MS  = 20,
  parameter int TIMEOUT_MS = 5000,
  parameter int BRAKE_MS   = 10,
  parameter int CNT_W      = 13
) (
  input  logic               CLOCK,
  input  logic               rst,
  input  logic               tick_ms,
  input  logic               LITE_DC_ON,
  input  logic               PWR_AUTO_TAPE_START,
  input  logic               REQ_IO,
  input  logic               REQ_MANUAL,
  input  logic               TAPE_FRAME,
  input  logic               TAPE_BLOCK_END,
  output logic               TAPE_MOTOR_ON,
  output logic               WAIT_FOR_TAPE,
  output logic [GRANT_W-1:0] GRANT,
  output logic               TAPE_TIMEOUT
);

  localparam logic [CNT_W-1:0] SPIN_CNT = CNT_W'(SPINUP_MS);
  localparam logic [CNT_W-1:0] TO_CNT   = CNT_W'(TIMEOUT_MS);
  localparam logic [CNT_W-1:0] BRK_CNT  = CNT_W'(BRAKE_MS);

  tape_state_t        state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
  logic [GRANT_W-1:0] grant_q, grant_d;
  logic               timeout_q, timeout_d;

  logic [GRANT_W-1:0] req_vec;
  logic [GRANT_W-1:0] pend;
  logic [GRANT_W-1:0] sel;
  logic [GRANT_W-1:0] clr;
  logic               issue;

  assign req_vec[SRC_AUTO]   = PWR_AUTO_TAPE_START;
  assign req_vec[SRC_IO]     = REQ_IO;
  assign req_vec[SRC_MANUAL] = REQ_MANUAL;

  for (genvar i = 0; i < GRANT_W; i++) begin : g_req
    tape_req_latch u_latch (
      .clk       (CLOCK),
      .rst       (rst),
      .req_i     (req_vec[i]),
      .set_ok_i  (LITE_DC_ON),
      .clr_i     (clr[i]),
      .pending_o (pend[i])
    );
  end

  // Fixed priority pick among pending sources: auto, then io, then manual.
  always_comb begin
    sel = '0;
    if (pend[SRC_AUTO]) begin
      sel[SRC_AUTO] = 1'b1;
    end else if (pend[SRC_IO]) begin
      sel[SRC_IO] = 1'b1;
    end else if (pend[SRC_MANUAL]) begin
      sel[SRC_MANUAL] = 1'b1;
    end
  end

  assign issue   = (state_q == IDLE) && LITE_DC_ON && (|pend);
  assign clr     = (issue ? sel : '0) | {GRANT_W{~LITE_DC_ON}};
  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

  // State register with the ms counter, owner and timeout pulse.
  always_ff @(posedge CLOCK) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      grant_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      grant_q   <= grant_d;
      timeout_q <= timeout_d;
    end
  end

  // Next-state: power loss overrides everything; block end beats timeout in READ.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    grant_d   = grant_q;
    timeout_d = 1'b0;
    if (!LITE_DC_ON) begin
      state_d = IDLE;
      cnt_d   = '0;
      grant_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|pend) begin
            grant_d = sel;
            cnt_d   = '0;
            state_d = SPINUP;
          end
        end
        SPINUP: begin
          if (cnt_q == SPIN_CNT) begin
            cnt_d   = '0;
            state_d = READ;
          end else if (tick_ms) begin
            cnt_d = cnt_inc;
          end
        end
        READ: begin
          if (TAPE_BLOCK_END) begin
            cnt_d   = '0;
            state_d = BRAKE;
          end else if (cnt_q == TO_CNT) begin
            timeout_d = 1'b1;
            cnt_d     = '0;
            state_d   = BRAKE;
          end else if (TAPE_FRAME) begin
            cnt_d = '0;
          end else if (tick_ms) begin
            cnt_d = cnt_inc;
          end
        end
        BRAKE: begin
          if (cnt_q == BRK_CNT) begin
            cnt_d   = '0;
            grant_d = '0;
            state_d = IDLE;
          end else if (tick_ms) begin
            cnt_d = cnt_inc;
          end
        end
        default: begin
          cnt_d   = '0;
          grant_d = '0;
          state_d = IDLE;
        end
      endcase
    end
  end

  // Outputs decoded from the registered state.
  always_comb begin
    WAIT_FOR_TAPE = (state_q != IDLE);
    TAPE_MOTOR_ON = (state_q == SPINUP) || (state_q == READ);
    GRANT         = grant_q;
    TAPE_TIMEOUT  = timeout_q;
  end

endmodule

// File: tb/tb_tape_start_ctl.sv
// tb/tb_tape_start_ctl.sv - scoreboard bench for tape_start_ctl
module tb_tape_start_ctl;

  logic       CLOCK = 1'b0;
  logic       rst = 1'b1;
  logic       tick_ms = 1'b0;
  logic       LITE_DC_ON = 1'b1;
  logic       PWR_AUTO_TAPE_START = 1'b0;
  logic       REQ_IO = 1'b0;
  logic       REQ_MANUAL = 1'b0;
  logic       TAPE_FRAME = 1'b0;
  logic       TAPE_BLOCK_END = 1'b0;
  logic       TAPE_MOTOR_ON;
  logic       WAIT_FOR_TAPE;
  logic [2:0] GRANT;
  logic       TAPE_TIMEOUT;

  tape_start_ctl dut (
    .CLOCK               (CLOCK),
    .rst                 (rst),
    .tick_ms             (tick_ms),
    .LITE_DC_ON          (LITE_DC_ON),
    .PWR_AUTO_TAPE_START (PWR_AUTO_TAPE_START),
    .REQ_IO              (REQ_IO),
    .REQ_MANUAL          (REQ_MANUAL),
    .TAPE_FRAME          (TAPE_FRAME),
    .TAPE_BLOCK_END      (TAPE_BLOCK_END),
    .TAPE_MOTOR_ON       (TAPE_MOTOR_ON),
    .WAIT_FOR_TAPE       (WAIT_FOR_TAPE),
    .GRANT               (GRANT),
    .TAPE_TIMEOUT        (TAPE_TIMEOUT)
  );

  localparam int SPIN = 20;
  localparam int TO   = 5000;
  localparam int BRK  = 10;

  typedef struct {
    logic [5:0] v;
    int         at;
  } ev_t;

  ev_t  q[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_bad = 0;
  logic mon_en = 1'b0;
  int   rst_chk_at = -1;
  int   final_at = -1;

  always #5 CLOCK = ~CLOCK;

  always @(posedge CLOCK) cyc <= cyc + 1;

  // Monitor: output vector {GRANT, WAIT, MOTOR, TIMEOUT}; every change pops one expectation.
  initial begin
    logic [5:0] prev;
    logic [5:0] vec;
    ev_t        e;
    prev = 6'b0;
    forever begin
      @(negedge CLOCK);
      if (mon_en) begin
        vec = {GRANT, WAIT_FOR_TAPE, TAPE_MOTOR_ON, TAPE_TIMEOUT};
        if (cyc == rst_chk_at) begin
          n_vec++;
          if (vec !== 6'b0) begin
            n_bad++;
            $display("FAIL reset_state got=%b want=000000 cyc=%0d", vec, cyc);
          end
        end
        if (vec !== prev) begin
          n_vec++;
          if (q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_change got=%b@%0d want=no_change", vec, cyc);
          end else begin
            e = q.pop_front();
            if (e.v !== vec || e.at != cyc) begin
              n_bad++;
              $display("FAIL event got=%b@%0d want=%b@%0d", vec, cyc, e.v, e.at);
            end
          end
          prev = vec;
        end else if (q.size() > 0 && q[0].at < cyc) begin
          e = q.pop_front();
          n_vec++;
          n_bad++;
          $display("FAIL missed_event got=%b@%0d want=%b@%0d", vec, cyc, e.v, e.at);
        end
        if (cyc == final_at) begin
          n_vec++;
          if (q.size() != 0) begin
            n_bad++;
            $display("FAIL leftover_events got=%0d want=0", q.size());
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic expect_ev(input logic [5:0] v, input int at);
    ev_t e;
    e.v  = v;
    e.at = at;
    q.push_back(e);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick_ms = 1'b1;
      step();
    end
    tick_ms = 1'b0;
  endtask

  // Entered right as SPINUP begins: spin up, read nframes, block end, brake back to IDLE.
  task automatic read_block(input logic [2:0] g, input int nframes);
    ticks(SPIN);
    step();
    for (int k = 0; k < nframes; k++) begin
      tick_ms = 1'b1;
      step();
      tick_ms = 1'b0;
      TAPE_FRAME = 1'b1;
      step();
      TAPE_FRAME = 1'b0;
    end
    expect_ev({g, 3'b100}, cyc + 1);
    TAPE_BLOCK_END = 1'b1;
    step();
    TAPE_BLOCK_END = 1'b0;
    expect_ev(6'b0, cyc + BRK + 1);
    ticks(BRK);
    step();
  endtask

  initial begin
    int s;
    repeat (3) step();
    rst = 1'b0;
    rst_chk_at = cyc;
    mon_en = 1'b1;

    // Single auto block with frames.
    expect_ev({3'b001, 3'b110}, cyc + 2);
    PWR_AUTO_TAPE_START = 1'b1;
    step(); step();
    read_block(3'b001, 5);
    PWR_AUTO_TAPE_START = 1'b0;
    step();

    // Three simultaneous edges: auto, io, manual in order.
    expect_ev({3'b001, 3'b110}, cyc + 2);
    PWR_AUTO_TAPE_START = 1'b1;
    REQ_IO = 1'b1;
    REQ_MANUAL = 1'b1;
    step(); step();
    read_block(3'b001, 0);
    expect_ev({3'b010, 3'b110}, cyc + 1);
    step();
    read_block(3'b010, 0);
    expect_ev({3'b100, 3'b110}, cyc + 1);
    step();
    read_block(3'b100, 0);
    repeat (20) step();
    PWR_AUTO_TAPE_START = 1'b0;
    REQ_IO = 1'b0;
    REQ_MANUAL = 1'b0;
    step();

    // Frame coincident with a tick at count 4999 restarts the window, then a full timeout.
    expect_ev({3'b010, 3'b110}, cyc + 2);
    REQ_IO = 1'b1;
    step(); step();
    ticks(SPIN);
    step();
    ticks(TO - 1);
    tick_ms = 1'b1;
    TAPE_FRAME = 1'b1;
    step();
    tick_ms = 1'b0;
    TAPE_FRAME = 1'b0;
    s = cyc;
    expect_ev({3'b010, 3'b101}, s + TO + 1);
    expect_ev({3'b010, 3'b100}, s + TO + 2);
    ticks(TO);
    step();
    expect_ev(6'b0, cyc + BRK + 1);
    ticks(BRK);
    step();
    REQ_IO = 1'b0;
    step();

    // Block end on the timeout cycle: brake with no timeout pulse.
    expect_ev({3'b010, 3'b110}, cyc + 2);
    REQ_IO = 1'b1;
    step(); step();
    ticks(SPIN);
    step();
    ticks(TO);
    expect_ev({3'b010, 3'b100}, cyc + 1);
    TAPE_BLOCK_END = 1'b1;
    step();
    TAPE_BLOCK_END = 1'b0;
    expect_ev(6'b0, cyc + BRK + 1);
    ticks(BRK);
    step();
    REQ_IO = 1'b0;
    step();

    // Power drop mid-READ with manual pending; edges while down are ignored.
    expect_ev({3'b010, 3'b110}, cyc + 2);
    REQ_IO = 1'b1;
    step(); step();
    ticks(SPIN);
    step();
    ticks(3);
    REQ_MANUAL = 1'b1;
    step(); step();
    expect_ev(6'b0, cyc + 1);
    LITE_DC_ON = 1'b0;
    step();
    PWR_AUTO_TAPE_START = 1'b1;
    step(); step();
    LITE_DC_ON = 1'b1;
    repeat (20) step();
    REQ_MANUAL = 1'b0;
    REQ_IO = 1'b0;
    PWR_AUTO_TAPE_START = 1'b0;
    step();

    // Reset mid-SPINUP with auto held high: no re-grant until a new edge.
    expect_ev({3'b001, 3'b110}, cyc + 2);
    PWR_AUTO_TAPE_START = 1'b1;
    step(); step();
    ticks(5);
    expect_ev(6'b0, cyc + 1);
    rst_chk_at = cyc + 1;
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (20) step();
    PWR_AUTO_TAPE_START = 1'b0;
    step();
    expect_ev({3'b001, 3'b110}, cyc + 2);
    PWR_AUTO_TAPE_START = 1'b1;
    step(); step();
    read_block(3'b001, 2);

    repeat (10) step();
    final_at = cyc + 1;
    step(); step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/tape_start_ctl.md
# tape_start_ctl

Sequencer and arbiter for the photoelectric tape reader. Accepts block-read requests from three sources: the turn-on sequencer's auto tape start, the console manual start and the I/O command logic. It grants the reader to one source at a time, times motor spin-up, read inactivity and braking from the 1 ms tick of `timer`, and drives `WAIT_FOR_TAPE` back to `turn_on` while a block is being read.

## Interface
- `SPINUP_MS`, 20: motor spin-up time in ms before frames are accepted.
- `TIMEOUT_MS`, 5000: maximum ms between frames in READ before abort.
- `BRAKE_MS`, 10: motor-off dwell in ms before the reader may be re-granted.
- `CNT_W`, 13: ms counter width; must hold max(SPINUP_MS, TIMEOUT_MS, BRAKE_MS).
- `CLOCK`  in  1  system clock; single clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `tick_ms`  in  1  one-cycle pulse every 1 ms, from `timer`.
- `LITE_DC_ON`  in  1  DC power on; low aborts everything.
- `PWR_AUTO_TAPE_START`  in  1  turn-on request; rising edge requests.
- `REQ_IO`  in  1  I/O command request; rising edge requests.
- `REQ_MANUAL`  in  1  console tape-start request; rising edge requests.
- `TAPE_FRAME`  in  1  one-cycle strobe per frame read.
- `TAPE_BLOCK_END`  in  1  one-cycle strobe on stop code.
- `TAPE_MOTOR_ON`  out  1  reader motor drive.
- `WAIT_FOR_TAPE`  out  1  a block read is in progress (to `turn_on`).
- `GRANT`  out  3  one-hot owner: [0] auto, [1] io, [2] manual.
- `TAPE_TIMEOUT`  out  1  one-cycle pulse on inactivity abort.

## Operation
- Each source has an edge detector and a pending bit. A rising edge sets pending. Pending clears in the cycle the grant is issued to that source.
- A request edge from the current owner while it is granted stays pending and is serviced after the current read completes.
- Fixed priority among pending bits: auto > io > manual.
- States: IDLE, SPINUP, READ, BRAKE.
- IDLE: if any pending and `LITE_DC_ON`, load `GRANT`, clear the counter and go to SPINUP.
- SPINUP: motor on. The counter increments on `tick_ms`. At the count `SPINUP_MS`, clear the counter and go to READ. Frames seen here are ignored.
- READ: motor on. `TAPE_FRAME` clears the counter; otherwise `tick_ms` increments it.
  - `TAPE_BLOCK_END` goes to BRAKE.
  - A count of `TIMEOUT_MS` pulses `TAPE_TIMEOUT` and goes to BRAKE.
- BRAKE: motor off. At a count of `BRAKE_MS`, clear `GRANT` and go to IDLE.
- `WAIT_FOR_TAPE` = state != IDLE. `TAPE_MOTOR_ON` = SPINUP or READ.
- `LITE_DC_ON` low in any state: next cycle goes to IDLE, clears `GRANT` and all pending bits, and turns the motor off. No timeout pulse. Edges are ignored while `LITE_DC_ON` is low.
- Counter saturates at all-ones; it never wraps.

## Timing
- Reset values: every output is 0, state IDLE, pending 0, counter 0. Edge-detector history registers load the current input value, so a request already high during reset does not generate an edge.
- Request edge to pending: 1 cycle. Pending to `GRANT` and `WAIT_FOR_TAPE` high: 1 cycle, so 2 cycles from the edge when idle.
- Simultaneous events in the same cycle:
  - `TAPE_BLOCK_END` and a timeout: block end wins, no `TAPE_TIMEOUT` pulse.
  - `TAPE_FRAME` and `tick_ms`: the counter becomes 0.
  - Several request edges: all latch; priority decides the order of service.
- Minimum service time, grant to `WAIT_FOR_TAPE` low: SPINUP_MS + BRAKE_MS ticks plus read time.
- `rst` mid-operation: all state is restored to reset values on the next edge; any in-flight read is lost.

## Structure
- Shared package `g15_pkg` holds:
  - the `tape_state_t` enum (IDLE, SPINUP, READ, BRAKE);
  - the source index constants (SRC_AUTO=0, SRC_IO=1, SRC_MANUAL=2);
  - the `GRANT` width constant.
- Sub-module `tape_req_latch` holds the edge detector and pending bit, with `set_ok` and `clr` inputs. It is instantiated three times.
- The top level holds the state register, the priority encoder and the ms counter.

## Test plan
- Reset, then auto edge: `GRANT`=001 and `WAIT_FOR_TAPE`=1 two cycles after the edge. Motor on for 20 ticks before READ. Frames every 1 ms, then `TAPE_BLOCK_END`: motor off at once, `WAIT_FOR_TAPE` low 10 ticks later.
- Auto, io and manual edges in the same cycle: serviced in order 001, 010, 100, each separated by BRAKE. All three pending bits are cleared at the end.
- READ with no frames: `TAPE_TIMEOUT` pulses once after 5000 ticks, then BRAKE. A frame at tick 4999 restarts the 5000-tick window.
- `TAPE_BLOCK_END` coincident with the timeout tick: no `TAPE_TIMEOUT` pulse; goes to BRAKE.
- `LITE_DC_ON` dropped mid-READ with manual pending: next cycle IDLE, `GRANT`=000, motor off, pending cleared. Manual is not serviced after `LITE_DC_ON` returns.
- `rst` pulsed mid-SPINUP with `PWR_AUTO_TAPE_START` held high: all outputs 0; no re-grant until a new rising edge.
